period_meter: RTL and testbench

- Measures the period and high time of a slow, free-running square wave, in cycles of the fast system clock.
- Primary source is the divided clock produced by the team's programmable clock divider, so it recovers that divider's divisor.
- Used for self-check of divider settings and for frequency readout to the display/UART logic.
- Input is treated as asynchronous: it is synchronised, edge-detected, and timed by a saturating-timeout counter FSM.

---
 rtl/period_meter.sv | 126 ++++++++++++
 tb/tb_period_meter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// Period / high-time meter for a slow asynchronous square wave, counted in clk cycles.
// Synchroniser + edge detector feed a single IDLE/ARM/RUN FSM with a saturating timeout.
module period_meter #(
  parameter int unsigned      WIDTH   = 28,
  parameter logic [WIDTH-1:0] TIMEOUT = WIDTH'(200_000_000)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN
  } state_t;

  state_t           state_q;
  logic             s1_q, s2_q, s3_q;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hcap_q;
  logic [WIDTH-1:0] period_q, high_q;
  logic             valid_q, locked_q, timeout_q;
  logic             rise, fall, at_limit;

  // s3 is a history flop, so both edges see the same 3-cycle latency.
  assign rise     = s2_q & ~s3_q;
  assign fall     = ~s2_q & s3_q;
  assign at_limit = (cnt_q == TIMEOUT);

  always_comb begin
    cnt_d = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      cnt_q     <= '0;
      hcap_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      s1_q      <= sig_in;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      if (!enable) begin
        state_q  <= IDLE;
        locked_q <= 1'b0;
        cnt_q    <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            cnt_q   <= '0;
            state_q <= ARM;
          end
          ARM: begin
            // The first partial period is discarded; timing starts at this rise.
            if (rise) begin
              cnt_q   <= WIDTH'(1);
              hcap_q  <= '0;
              state_q <= RUN;
            end else if (at_limit) begin
              timeout_q <= 1'b1;
              locked_q  <= 1'b0;
              period_q  <= '0;
              high_q    <= '0;
              hcap_q    <= '0;
              cnt_q     <= '0;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          RUN: begin
            // A rise on the timeout cycle still counts as a good measurement.
            if (rise) begin
              period_q <= cnt_q;
              high_q   <= hcap_q;
              hcap_q   <= '0;
              valid_q  <= 1'b1;
              locked_q <= 1'b1;
              cnt_q    <= WIDTH'(1);
            end else if (at_limit) begin
              timeout_q <= 1'b1;
              locked_q  <= 1'b0;
              period_q  <= '0;
              high_q    <= '0;
              hcap_q    <= '0;
              cnt_q     <= '0;
              state_q   <= ARM;
            end else begin
              cnt_q <= cnt_d;
              if (fall) begin
                hcap_q <= cnt_q;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign locked    = locked_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: a divider-style stimulus queues the expected
// valid/timeout events, and a negedge monitor pops and compares whatever the DUT emits.
module tb_period_meter;
  localparam int W  = 28;
  localparam int TO = 20;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         sig_in = 1'b0;
  logic [W-1:0] period, high_time;
  logic         valid, locked, timeout;

  period_meter #(.WIDTH(W), .TIMEOUT(W'(TO))) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .sig_in    (sig_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .locked    (locked),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_to;
    int per;
    int hi;
    bit gap;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_vcyc = 0;
  bit   armed = 0;
  int   last_div = 0;
  int   last_high = 0;

  function automatic void chk(string nm, int act, int expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endfunction

  function automatic void push_exp(bit is_to, int per, int hi, bit gap);
    exp_t e;
    e.is_to = is_to;
    e.per   = per;
    e.hi    = hi;
    e.gap   = gap;
    q.push_back(e);
  endfunction

  // Monitor: every valid or timeout pulse must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!reset && (valid === 1'b1 || timeout === 1'b1)) begin
      chk("valid_timeout_exclusive", int'(valid & timeout), 0);
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_event: valid=%0b timeout=%0b period=%0d, expected none (cycle %0d)",
                 valid, timeout, period, cyc);
      end else begin
        e = q.pop_front();
        chk("event_kind_is_timeout", int'(timeout), int'(e.is_to));
        chk("period", int'(period), e.per);
        chk("high_time", int'(high_time), e.hi);
        chk("locked_at_event", int'(locked), e.is_to ? 0 : 1);
        if (e.gap) chk("timeout_gap_cycles", cyc - last_vcyc, TO);
        $display("event %s: period=%0d high_time=%0d locked=%0b (cycle %0d)",
                 timeout ? "timeout" : "valid", period, high_time, locked, cyc);
      end
      if (valid === 1'b1) last_vcyc = cyc;
    end
  end

  // ev: 1 = drop enable for 5 cycles, 2 = one-cycle reset, 3 = check still unlocked.
  task automatic run_div(input int div, input int nper, input int evp, input int ev);
    int h;
    h = (div + 1) / 2;
    for (int p = 0; p < nper; p++) begin
      for (int j = 0; j < div; j++) begin
        @(posedge clk);
        #1;
        if (j == 0) begin
          if (armed) push_exp(1'b0, last_div, last_high, 1'b0);
          armed     = 1;
          last_div  = div;
          last_high = h;
        end
        sig_in = (j < h);
        if (p == evp) begin
          case (ev)
            1: begin
              if (j == 4) enable = 1'b0;
              if (j == 7) begin
                chk("disabled_locked", int'(locked), 0);
                chk("disabled_period_held", int'(period), div);
              end
              if (j == 9) begin
                enable = 1'b1;
                armed  = 0;
              end
            end
            2: begin
              if (j == 6) reset = 1'b1;
              if (j == 7) begin
                reset = 1'b0;
                armed = 0;
              end
              if (j == 8) begin
                chk("rst_period", int'(period), 0);
                chk("rst_high_time", int'(high_time), 0);
                chk("rst_locked", int'(locked), 0);
                chk("rst_valid", int'(valid), 0);
                chk("rst_timeout", int'(timeout), 0);
              end
            end
            3: begin
              if (j == 5) chk("unlocked_after_first_rise", int'(locked), 0);
            end
            default: ;
          endcase
        end
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_period", int'(period), 0);
    chk("reset_high_time", int'(high_time), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_locked", int'(locked), 0);
    chk("reset_timeout", int'(timeout), 0);
    reset  = 1'b0;
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_div(10, 5, 0, 3);
    run_div(7, 4, -1, 0);
    run_div(2, 6, -1, 0);

    // Loss of signal: hold low well past TIMEOUT cycles after the last rise.
    run_div(10, 4, -1, 0);
    push_exp(1'b1, 0, 0, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    armed = 0;
    chk("locked_after_timeout", int'(locked), 0);
    run_div(10, 3, -1, 0);

    run_div(10, 4, 1, 1);
    run_div(12, 4, 1, 2);
    // Boundary: each rise lands exactly when the counter equals TIMEOUT.
    run_div(20, 4, -1, 0);

    @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    chk("final_locked_after_disable", int'(locked), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
